// File: rtl/cic_decimator_mc.sv
// -----------------------------------------------------------------------------
// cic_decimator_mc
//   Parametrised N-stage CIC decimator with runtime decimation ratio, comb
//   differential delay M, pipelined combs, runtime arithmetic right shift and
//   output saturation. Sits between the sample front-end (in_valid strobe)
//   and downstream compensation filtering (out_valid strobe).
//
// Parameters
//   N      number of integrator and comb stages (1..8)
//   M      comb differential delay (1 or 2)
//   IN_W   signed input width
//   OUT_W  signed output width
//   RMAX   largest supported decimation ratio
//   ACC_W  (derived) internal accumulator width IN_W + N*clog2(RMAX*M)
//
// Ports
//   clk        single clock, all registers on posedge
//   rst_n      asynchronous active-low reset
//   ratio      decimation ratio R (0/1 = no decimation, > RMAX clamps)
//   shift      arithmetic right shift applied to the comb output
//   in_valid   in_data is valid this cycle
//   in_data    signed input sample
//   out_valid  one-cycle pulse, out_data valid
//   out_data   signed decimated output, held between pulses
//   out_sat    pulses with out_valid when out_data was clamped
//
// Configuration macro
//   CIC_ROUND_EN  when defined, the shift rounds half up instead of
//                 truncating; when undefined no rounding logic exists.
// -----------------------------------------------------------------------------
module cic_decimator_mc #(
    parameter int N     = 5,
    parameter int M     = 1,
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int RMAX  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      ratio,
    input  logic [5:0]       shift,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat
);

    localparam int ACC_W = IN_W + N * $clog2(RMAX * M);
    localparam int CNT_W = $clog2(RMAX + 1);
    // Post-shift width: wide enough for the rounding carry and for a signed
    // comparison against the OUT_W limits without losing the sign.
    localparam int YW    = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;

    localparam logic signed [YW-1:0] SAT_MAX = {{(YW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [YW-1:0] SAT_MIN = ~SAT_MAX;

    // ------------------------------------------------------------------
    // Ratio handling and phase counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]        w_ratio_clamp;
    logic [CNT_W-1:0]        w_ratio_eff;
    logic                    w_wrap;
    logic                    w_strobe;
    logic signed [ACC_W-1:0] w_in_ext;

    logic [CNT_W-1:0]        r_ratio_act;
    logic                    r_started;
    logic [CNT_W-1:0]        r_phase;
    logic signed [ACC_W-1:0] r_integ [N];
    logic signed [ACC_W-1:0] r_cap;
    logic                    r_cap_v;

    // NOTE: every always_comb output gets a value on every path so no latch
    // is inferred.
    always_comb begin
        w_ratio_clamp = CNT_W'(ratio);
        if (32'(ratio) > RMAX) begin
            w_ratio_clamp = CNT_W'(RMAX);
        end
    end

    // The first cycle after reset release uses the live ratio; afterwards the
    // ratio only changes at a phase wrap so a phase is never truncated.
    assign w_ratio_eff = r_started ? r_ratio_act : w_ratio_clamp;
    assign w_wrap      = (w_ratio_eff <= CNT_W'(1)) || (r_phase == w_ratio_eff - CNT_W'(1));
    assign w_strobe    = in_valid & w_wrap;
    assign w_in_ext    = ACC_W'($signed(in_data));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the Hogenauer integrator chain depends on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: integrators and comb delay lines are explicitly reset; a
            // restart must begin from a zero state, not from stale history.
            for (int k = 0; k < N; k++) begin
                r_integ[k] <= '0;
            end
            r_phase     <= '0;
            r_ratio_act <= '0;
            r_started   <= 1'b0;
            r_cap       <= '0;
            r_cap_v     <= 1'b0;
        end else begin
            r_started <= 1'b1;
            if (!r_started) begin
                r_ratio_act <= w_ratio_clamp;
            end
            r_cap_v <= w_strobe;
            if (in_valid) begin
                r_integ[0] <= r_integ[0] + w_in_ext;
                for (int k = 1; k < N; k++) begin
                    r_integ[k] <= r_integ[k] + r_integ[k-1];
                end
                if (w_wrap) begin
                    r_phase     <= '0;
                    r_ratio_act <= w_ratio_clamp;
                    r_cap       <= r_integ[N-1];
                end else begin
                    r_phase <= r_phase + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Comb pipeline: one registered stage per clock, advanced by its own
    // valid bit rather than by in_valid.
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] r_comb [N];
    logic signed [ACC_W-1:0] r_dly  [N][M];
    logic [N-1:0]            r_cvalid;
    logic signed [ACC_W-1:0] w_stage_in [N];
    logic [N-1:0]            w_stage_v;

    assign w_stage_in[0] = r_cap;
    for (genvar k = 1; k < N; k++) begin : g_stage_in
        assign w_stage_in[k] = r_comb[k-1];
    end

    // Stage k is fed by the valid of stage k-1 (stage 0 by the capture valid).
    assign w_stage_v = N'({r_cvalid, r_cap_v});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                r_comb[k] <= '0;
                for (int j = 0; j < M; j++) begin
                    r_dly[k][j] <= '0;
                end
            end
            r_cvalid <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_stage_v[k]) begin
                    r_comb[k]   <= w_stage_in[k] - r_dly[k][M-1];
                    r_dly[k][0] <= w_stage_in[k];
                    for (int j = 1; j < M; j++) begin
                        r_dly[k][j] <= r_dly[k][j-1];
                    end
                end
            end
            r_cvalid <= w_stage_v;
        end
    end

    // ------------------------------------------------------------------
    // Output scaling and saturation
    // ------------------------------------------------------------------
    logic signed [YW-1:0]    w_cn_ext;
    logic signed [YW-1:0]    w_y;
    logic [OUT_W-1:0]        w_narrow;
    logic                    w_sat;

    assign w_cn_ext = YW'(r_comb[N-1]);

`ifdef CIC_ROUND_EN
    logic signed [YW-1:0]    w_half;
    logic signed [YW-1:0]    w_sum;

    // Half an output LSB; the widened adder cannot wrap.
    assign w_half = (shift == 6'd0) ? '0 : (YW'(1) << (shift - 6'd1));
    assign w_sum  = w_cn_ext + w_half;
    assign w_y    = w_sum >>> shift;
`else
    // Shifts at or beyond the accumulator width leave pure sign fill.
    assign w_y    = w_cn_ext >>> shift;
`endif

    always_comb begin
        w_narrow = w_y[OUT_W-1:0];
        w_sat    = 1'b0;
        if (w_y > SAT_MAX) begin
            w_narrow = SAT_MAX[OUT_W-1:0];
            w_sat    = 1'b1;
        end else if (w_y < SAT_MIN) begin
            w_narrow = SAT_MIN[OUT_W-1:0];
            w_sat    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= r_cvalid[N-1];
            out_sat   <= r_cvalid[N-1] & w_sat;
            if (r_cvalid[N-1]) begin
                out_data <= w_narrow;
            end
        end
    end

endmodule
